// File: rtl/piece_scheduler_if.sv
// Handshake and data bundle between the piece scheduler and the game-control logic.
interface piece_scheduler_if #(
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]         RAND;
  logic               REQ;
  logic               ACK;
  logic [2:0]         CUR_PIECE;
  logic               CUR_VALID;
  logic [3*DEPTH-1:0] PREVIEW;
  logic [CW-1:0]      COUNT;

  modport master (
    output RAND, REQ,
    input  ACK, CUR_PIECE, CUR_VALID, PREVIEW, COUNT
  );

  modport slave (
    input  RAND, REQ,
    output ACK, CUR_PIECE, CUR_VALID, PREVIEW, COUNT
  );
endinterface

// File: rtl/piece_scheduler.sv
// 7-bag tetromino scheduler: filters the LFSR stream into a fair bag sequence,
// keeps a preview queue topped up and grants pieces over REQ/ACK.
module piece_scheduler #(
  parameter int DEPTH       = 3,
  parameter int RETRY_LIMIT = 15
) (
  input  logic            CLK,
  input  logic            RESET_N,
  piece_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0]    RL  = 8'(RETRY_LIMIT);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);

  logic [DEPTH-1:0][2:0] q_q, q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [6:0]            used_q, used_d;
  logic [7:0]            rej_q, rej_d;
  logic                  ack_q;
  logic [2:0]            cur_q;
  logic                  curv_q;

  logic [2:0]    rsel, free_id, cand;
  logic          accept, free_ok, at_limit, cand_vld;
  logic          pop, space, push;
  logic [CW-1:0] wr_idx;
  logic [6:0]    used_set;

  // Lowest-index piece still missing from the current bag (fallback source).
  always_comb begin
    free_id = 3'd0;
    free_ok = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!used_q[i]) begin
        free_id = 3'(i);
        free_ok = 1'b1;
      end
    end
  end

  // Candidate pick, pop/push decisions and next-state for queue, bag and retry counter.
  always_comb begin
    rsel     = bus.RAND[2:0];
    accept   = (bus.RAND < 4'd7) && !used_q[rsel];
    at_limit = (rej_q == RL);
    cand     = at_limit ? free_id : rsel;
    cand_vld = at_limit ? free_ok : accept;
    pop      = bus.REQ && !ack_q && (cnt_q != '0);
    space    = (cnt_q < DMAX) || pop;
    push     = cand_vld && space;

    // shift toward head on pop, then write the tail slot left after the shift
    q_d = q_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
      q_d[DEPTH-1] = 3'h7;
    end
    wr_idx = cnt_q - CW'(pop);
    if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == wr_idx) q_d[i] = cand;
    end

    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // completing a bag restarts it on the same edge
    used_set = used_q | (7'd1 << cand);
    used_d   = used_q;
    if (push) used_d = (used_set == 7'h7F) ? 7'h00 : used_set;

    rej_d = rej_q;
    if (push)                      rej_d = 8'd0;
    else if (space && !at_limit)   rej_d = rej_q + 8'd1;
  end

  // State registers; reset clears the bag and drops any pending request.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_q    <= {DEPTH{3'h7}};
      cnt_q  <= '0;
      used_q <= 7'h00;
      rej_q  <= 8'd0;
      ack_q  <= 1'b0;
      cur_q  <= 3'h7;
      curv_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      used_q <= used_d;
      rej_q  <= rej_d;
      ack_q  <= pop;
      if (pop) begin
        cur_q  <= q_q[0];
        curv_q <= 1'b1;
      end
    end
  end

  assign bus.ACK       = ack_q;
  assign bus.CUR_PIECE = cur_q;
  assign bus.CUR_VALID = curv_q;
  assign bus.PREVIEW   = q_q;
  assign bus.COUNT     = cnt_q;
endmodule

// File: doc/piece_scheduler.md
Name: piece_scheduler

Overview:
- Turns the raw 4-bit pseudo-random stream from the LFSR into a fair 7-bag sequence of tetromino IDs (0–6).
- Keeps a short preview queue of upcoming pieces full.
- Hands pieces to the game-control FSM over a REQ/ACK handshake.
- Sits between the random generator and the board/spawn logic; also drives the "next piece" display.

Parameters:
- DEPTH, 3, number of preview-queue entries (1–6).
- RETRY_LIMIT, 15, consecutive rejected random samples before the deterministic fallback fires (1–255).

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- RAND  input  4  random sample, new value every cycle (values 0–15)
- REQ  input  1  level request for the next piece; held until ACK is seen
- ACK  output  1  one-cycle pulse: CUR_PIECE updated with the granted piece
- CUR_PIECE  output  3  most recently granted piece ID
- CUR_VALID  output  1  high once at least one piece has been granted since reset
- PREVIEW  output  3*DEPTH  queue entries; entry 0 (head) in bits [2:0]; unoccupied entries read 3'h7
- COUNT  output  ceil(log2(DEPTH+1))  current queue occupancy

Behaviour:
- Reset (RESET_N low, asynchronous): all state and outputs take their reset values.
  - Queue state: bag mask USED[6:0]=0, COUNT=0, reject counter=0, all PREVIEW entries=3'h7.
  - Handshake/current piece: CUR_PIECE=3'h7, CUR_VALID=0, ACK=0.
  - An in-flight REQ is dropped. Operation resumes on the first rising edge after RESET_N deasserts.
- Candidate selection, combinational each cycle:
  - Accept when RAND<7 and USED[RAND[2:0]]=0; the candidate is RAND[2:0].
  - When the reject counter equals RETRY_LIMIT, the candidate is instead the lowest-index piece with USED=0 (fallback), regardless of RAND.
- Push:
  - A push occurs when a candidate exists and either COUNT<DEPTH or a pop occurs in the same cycle.
  - The candidate is written to the tail and its USED bit is set.
  - If USED would become 7'h7F after the set, USED clears to 0 in the same edge (new bag).
  - Reject counter resets to 0 on any push.
  - Reject counter increments when the queue has space but no candidate is accepted.
  - Reject counter holds when the queue is full with no pop, and saturates at RETRY_LIMIT.
- Pop / grant:
  - A pop occurs when REQ=1, ACK=0 and COUNT>0.
  - At the next edge: CUR_PIECE<=head, CUR_VALID<=1, ACK<=1, remaining entries shift toward the head.
  - Latency from REQ sampled to ACK is 1 cycle when COUNT>0.
  - ACK is high exactly one cycle. REQ still high during the ACK cycle does not cause a second pop, because pop requires ACK=0.
- REQ with COUNT=0: the request stays pending with no ACK. It is granted on the first edge where COUNT>0 is sampled, i.e. at least one cycle after the first push.
- Simultaneous pop and push with a full queue is legal. COUNT is unchanged and the new piece lands at the tail after the shift.
- Simultaneous pop and push with COUNT=0 is not possible: a pop requires COUNT>0 at sampling.
- Latency from a RAND sample accepted in cycle n to its appearance in PREVIEW/COUNT is edge n+1.
- Fairness guarantee: within each bag of 7 consecutive pushes after reset, every ID 0–6 appears exactly once.

Test Plan:
1. Reset, then drive RAND=2,2,9,5,1 with no REQ, DEPTH=3.
   Required: after 5 edges PREVIEW={2,5,1}, COUNT=3, USED=7'b0100110. The second 2 and the 9 are rejected.
2. Queue full {2,5,1}, hold RAND=0, assert REQ.
   Required: next edge ACK=1, CUR_PIECE=2, CUR_VALID=1, PREVIEW={5,1,0}, COUNT=3. Following cycle ACK=0 and no second pop while REQ remains high.
3. Drive RAND=0..6 in order with REQ pulsed so the queue never blocks, then RAND=3.
   Required: USED returns to 0 after the 7th push, and the 3 is accepted as the first piece of the new bag.
4. RETRY_LIMIT=4, queue has space, USED=7'b0000001, RAND held at 15.
   Required: 4 cycles with no push, then push of ID 1 (lowest free), and the reject counter returns to 0.
5. Immediately after reset assert REQ with RAND=15 for 3 cycles, then RAND=4.
   Required: no ACK while COUNT=0; 4 pushed, then ACK with CUR_PIECE=4 on the following edge.
6. RESET_N pulled low mid-cycle with COUNT=2 and REQ high.
   Required: outputs go to reset values immediately without waiting for CLK (COUNT=0, PREVIEW all 7, ACK=0, CUR_VALID=0).
